// File: rtl/seg_pkg.sv
// Shared segment encodings and bit positions for the 4-digit 7-segment scanner.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high g..a codes
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Non-BCD nibbles render as a dash so a bad upstream value is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to active-high 7-segment (g..a) decoder.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg_scan_4digit.sv
// Multiplexed 4-digit common-anode display scanner with per-slot blank gap,
// per-frame input snapshot and optional leading-zero suppression.
module seg_scan_4digit
  import seg_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] disp_data,
  input  logic [3:0]  dp_on,
  input  logic        lz_blank,
  output logic [7:0]  seg_n,
  output logic [3:0]  dig_sel_n
);

  localparam int DIV = CLK_FREQ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;

  logic          slot_end;
  logic          frame_end;
  logic          in_blank;
  logic          lz_hit;
  logic [3:0]    digit;
  logic [6:0]    code;
  logic [7:0]    seg_d;
  logic [3:0]    dig_d;

  assign slot_end  = (slot_cnt == CW'(DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);
  assign in_blank  = (int'(slot_cnt) < BLANK_CYCLES);
  assign digit     = shadow[{idx, 2'b00} +: 4];

  seg_decode u_decode (
    .bcd (digit),
    .seg (code)
  );

  // lz_blank is used live; only the digits and dps are frame-snapshotted.
  always_comb begin
    lz_hit = 1'b0;
    if (lz_blank) begin
      case (idx)
        2'd3:    lz_hit = (shadow[15:12] == 4'h0);
        2'd2:    lz_hit = (shadow[15:8]  == 8'h00);
        2'd1:    lz_hit = (shadow[15:4]  == 12'h000);
        default: lz_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    seg_d = 8'hFF;
    dig_d = 4'hF;
    if (!in_blank) begin
      dig_d                = ~(4'b0001 << idx);
      seg_d[SEG_DP]        = ~shadow_dp[idx];
      seg_d[SEG_G:SEG_A]   = lz_hit ? ~SEG_OFF : ~code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      idx       <= 2'd0;
      shadow    <= 16'h0000;
      shadow_dp <= 4'h0;
      seg_n     <= 8'hFF;
      dig_sel_n <= 4'hF;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + CW'(1);
      if (slot_end) idx <= idx + 2'd1;
      if (frame_end) begin
        shadow    <= disp_data;
        shadow_dp <= dp_on;
      end
      seg_n     <= seg_d;
      dig_sel_n <= dig_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_4digit.sv
// Directed bench for seg_scan_4digit with DIV=10 and a 2-clock blank gap.
module tb_seg_scan_4digit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] disp_data = 16'h0000;
  logic [3:0]  dp_on = 4'h0;
  logic        lz_blank = 1'b0;
  logic [7:0]  seg_n;
  logic [3:0]  dig_sel_n;

  int errors = 0;
  int checks = 0;
  int n = 0;  // clock edges since last reset release

  always #5 clk = ~clk;

  seg_scan_4digit #(
    .CLK_FREQ     (1000),
    .SCAN_HZ      (100),
    .BLANK_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_data (disp_data),
    .dp_on     (dp_on),
    .lz_blank  (lz_blank),
    .seg_n     (seg_n),
    .dig_sel_n (dig_sel_n)
  );

  // Output after edge n reflects the state before it: slot_cnt=(n-1)%10,
  // idx=((n-1)/10)%4; snapshot edges are n=40,80,...
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    checks++;
    if ($countones(~dig_sel_n) > 1) begin
      errors++;
      $display("FAIL onehot n=%0d dig_sel_n=%b want at most one low", n, dig_sel_n);
    end
  endtask

  task automatic goto(input int t);
    while (n < t) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({seg_n, dig_sel_n} !== 12'hFFF) begin
        errors++;
        $display("FAIL reset_hold got seg_n=%h dig_sel_n=%h want FF/F", seg_n, dig_sel_n);
      end
    end
    rst_n = 1'b1;
    n = 0;
    goto(1);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_blank0 got seg_n=%h dig_sel_n=%h want FF/F", seg_n, dig_sel_n);
    end
    goto(2);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFFF) begin
      errors++;
      $display("FAIL reset_blank1 got seg_n=%h dig_sel_n=%h want FF/F", seg_n, dig_sel_n);
    end
    goto(3);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0E) begin
      errors++;
      $display("FAIL reset_first_dk0 got seg_n=%h dig_sel_n=%h want C0/E", seg_n, dig_sel_n);
    end
  endtask

  task automatic test_digits();
    disp_data = 16'h0059;
    dp_on     = 4'h0;
    lz_blank  = 1'b0;
    goto(41);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFFF) begin
      errors++;
      $display("FAIL dk0_gap got seg_n=%h dig_sel_n=%h want FF/F", seg_n, dig_sel_n);
    end
    goto(43);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h90E) begin
      errors++;
      $display("FAIL dk0_nine got seg_n=%h dig_sel_n=%h want 90/E", seg_n, dig_sel_n);
    end
    goto(50);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h90E) begin
      errors++;
      $display("FAIL dk0_last got seg_n=%h dig_sel_n=%h want 90/E", seg_n, dig_sel_n);
    end
    goto(52);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFFF) begin
      errors++;
      $display("FAIL dk1_gap got seg_n=%h dig_sel_n=%h want FF/F", seg_n, dig_sel_n);
    end
    goto(53);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h92D) begin
      errors++;
      $display("FAIL dk1_five got seg_n=%h dig_sel_n=%h want 92/D", seg_n, dig_sel_n);
    end
    goto(63);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0B) begin
      errors++;
      $display("FAIL dk2_zero got seg_n=%h dig_sel_n=%h want C0/B", seg_n, dig_sel_n);
    end
    goto(73);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC07) begin
      errors++;
      $display("FAIL dk3_zero got seg_n=%h dig_sel_n=%h want C0/7", seg_n, dig_sel_n);
    end
  endtask

  task automatic test_lz_blank();
    goto(80);
    lz_blank = 1'b1;
    goto(83);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h90E) begin
      errors++;
      $display("FAIL lz_dk0 got seg_n=%h dig_sel_n=%h want 90/E", seg_n, dig_sel_n);
    end
    goto(93);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h92D) begin
      errors++;
      $display("FAIL lz_dk1 got seg_n=%h dig_sel_n=%h want 92/D", seg_n, dig_sel_n);
    end
    goto(103);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFFB) begin
      errors++;
      $display("FAIL lz_dk2 got seg_n=%h dig_sel_n=%h want FF/B", seg_n, dig_sel_n);
    end
    goto(113);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFF7) begin
      errors++;
      $display("FAIL lz_dk3 got seg_n=%h dig_sel_n=%h want FF/7", seg_n, dig_sel_n);
    end
  endtask

  task automatic test_snapshot();
    goto(120);
    lz_blank = 1'b0;
    goto(133);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h92D) begin
      errors++;
      $display("FAIL snap_dk1_before got seg_n=%h dig_sel_n=%h want 92/D", seg_n, dig_sel_n);
    end
    disp_data = 16'h0060;
    goto(135);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h92D) begin
      errors++;
      $display("FAIL snap_dk1_after got seg_n=%h dig_sel_n=%h want 92/D", seg_n, dig_sel_n);
    end
    goto(143);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0B) begin
      errors++;
      $display("FAIL snap_dk2 got seg_n=%h dig_sel_n=%h want C0/B", seg_n, dig_sel_n);
    end
    goto(163);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0E) begin
      errors++;
      $display("FAIL snap_new_dk0 got seg_n=%h dig_sel_n=%h want C0/E", seg_n, dig_sel_n);
    end
    goto(173);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h82D) begin
      errors++;
      $display("FAIL snap_new_dk1 got seg_n=%h dig_sel_n=%h want 82/D", seg_n, dig_sel_n);
    end
  endtask

  task automatic test_dash_dp();
    disp_data = 16'h00A0;
    dp_on     = 4'b0010;
    goto(203);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0E) begin
      errors++;
      $display("FAIL dash_dk0 got seg_n=%h dig_sel_n=%h want C0/E", seg_n, dig_sel_n);
    end
    goto(211);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFFF) begin
      errors++;
      $display("FAIL dash_gap got seg_n=%h dig_sel_n=%h want FF/F", seg_n, dig_sel_n);
    end
    goto(213);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'h3FD) begin
      errors++;
      $display("FAIL dash_dk1 got seg_n=%h dig_sel_n=%h want 3F/D", seg_n, dig_sel_n);
    end
  endtask

  task automatic test_mid_reset();
    goto(225);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0B) begin
      errors++;
      $display("FAIL mid_pre_dk2 got seg_n=%h dig_sel_n=%h want C0/B", seg_n, dig_sel_n);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFFF) begin
      errors++;
      $display("FAIL mid_reset got seg_n=%h dig_sel_n=%h want FF/F", seg_n, dig_sel_n);
    end
    rst_n = 1'b1;
    n = 0;
    goto(1);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hFFF) begin
      errors++;
      $display("FAIL mid_restart_gap got seg_n=%h dig_sel_n=%h want FF/F", seg_n, dig_sel_n);
    end
    goto(3);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0E) begin
      errors++;
      $display("FAIL mid_restart_dk0 got seg_n=%h dig_sel_n=%h want C0/E", seg_n, dig_sel_n);
    end
    goto(13);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0D) begin
      errors++;
      $display("FAIL mid_restart_dk1 got seg_n=%h dig_sel_n=%h want C0/D", seg_n, dig_sel_n);
    end
    goto(23);
    checks++;
    if ({seg_n, dig_sel_n} !== 12'hC0B) begin
      errors++;
      $display("FAIL mid_restart_dk2 got seg_n=%h dig_sel_n=%h want C0/B", seg_n, dig_sel_n);
    end
    goto(45);
  endtask

  initial begin
    test_reset();
    test_digits();
    test_lz_blank();
    test_snapshot();
    test_dash_dp();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_4digit.md
Name: seg_scan_4digit

Overview:
Multiplexed driver for the board's 4-digit common-anode 7-segment display. Consumes packed BCD words from upstream counters, e.g. the S3 press counter's 8-bit output on DK3-DK2 and a second pair on DK1-DK0. Scans one digit per slot, with an anti-ghosting blank gap between digits. Snapshots the input once per frame so a count change never tears mid-frame.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
SCAN_HZ, 1000, digit slot rate in Hz; DIV = CLK_FREQ/SCAN_HZ clocks per slot (default 50_000)
BLANK_CYCLES, 500, clocks at the start of each slot with all digits off; must be < DIV

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, synchronous, active-low
disp_data  in  16  four BCD digits: [15:12]=DK3, [11:8]=DK2, [7:4]=DK1, [3:0]=DK0
dp_on  in  4  decimal point enable per digit, bit k = DKk, active-high
lz_blank  in  1  1 = suppress leading zeros (DK0 is never suppressed)
seg_n  out  8  segments, active-low: [7]=dp, [6]=g ... [0]=a
dig_sel_n  out  4  digit enables, active-low, bit k = DKk

Behaviour:
- Reset is sampled only on a clk edge with rst_n=0. It is synchronous and active-low. It sets slot_cnt=0, idx=0, shadow=16'h0000, shadow_dp=4'h0, seg_n=8'hFF, dig_sel_n=4'hF.
- slot_cnt counts 0..DIV-1 and wraps to 0. On wrap, idx advances 0->1->2->3->0.
- Frame end is slot_cnt==DIV-1 with idx==3. In that same cycle, shadow<=disp_data and shadow_dp<=dp_on. At all other times the inputs are ignored, so an input change mid-frame takes effect only from the next frame's DK0 slot.
- seg_n and dig_sel_n are registered. Each is a function of the current slot_cnt, idx and shadow, so outputs lag the state by exactly 1 clk.
- When slot_cnt < BLANK_CYCLES: dig_sel_n=4'hF and seg_n=8'hFF.
- Otherwise: dig_sel_n = ~(4'b0001<<idx), and seg_n = ~{shadow_dp[idx], code7(shadow digit idx)}.
- code7 (active-high g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Non-BCD values A-F produce a dash (40).
- Leading-zero blanking applies only when lz_blank=1, and forces segments a-g off (seg_n[6:0]=7'h7F):
  - DK3 is blanked if DK3==0.
  - DK2 is blanked if DK3==0 and DK2==0.
  - DK1 is blanked if DK3, DK2 and DK1 are all 0.
  - DK0 is never blanked.
  - The digit enable still asserts on a blanked digit. Its dp still follows shadow_dp.
- lz_blank is sampled live, not snapshotted.
- rst_n low mid-slot: the next clk returns all state to reset values. The scan restarts at DK0 and the first frame shows 0000 (or just "0" with lz_blank=1).
- Exactly one dig_sel_n bit is low at any time, or none. Two or more bits low is never allowed.

Decomposition:
- Package seg_pkg holds:
  - the segment code constants SEG_0..SEG_9, SEG_DASH and SEG_OFF;
  - the bit-index constants for seg_n;
  - function bcd_to_seg(logic [3:0]) returning the 7-bit active-high code.
- One sub-module, seg_decode, is natural: combinational BCD to 7-segment, instantiated once on the muxed digit.
- Scan counter, snapshot and output registers stay in seg_scan_4digit.

Test Plan:
All scenarios run with CLK_FREQ=1000, SCAN_HZ=100 (DIV=10) and BLANK_CYCLES=2.
1. Hold reset 3 clks, then release. -> During reset seg_n=FF and dig_sel_n=F. The first frame shows 0 on all digits: at slot 0, cycle 3, dig_sel_n=E and seg_n=C0.
2. Set disp_data=16'h0059, dp_on=0, lz_blank=0 before a frame end. -> The next frame shows DK0 as 9 (seg_n=90, dig_sel_n=E), then DK1 as 5 (seg_n=92, dig_sel_n=D), then DK2 and DK3 as C0. Each slot has 2 leading clks with dig_sel_n=F.
3. Same data with lz_blank=1. -> DK3 and DK2 slots show seg_n=FF while their dig_sel_n bit is low. DK1 shows 92 and DK0 shows 90.
4. Change disp_data from 0059 to 0060 during the DK1 slot. -> The rest of the current frame still shows 0059. The new value first appears at the next DK0 slot (seg_n=C0).
5. disp_data=16'h00A0 with dp_on=4'b0010. -> The DK1 slot shows seg_n=3F (dash plus dp).
6. Pull rst_n low in the middle of the DK2 slot for 1 clk. -> The next clk gives seg_n=FF, dig_sel_n=F, and the scan restarts at DK0 with shadow=0000. At no cycle are two dig_sel_n bits low.
